// File: rtl/alu_mc_if.sv
// Handshaked operand/result bundle for alu_mc: Hack control bits, operands,
// and a registered result with valid/ready flow control.
interface alu_mc_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             zx;
    logic             nx;
    logic             zy;
    logic             ny;
    logic             f;
    logic             no;
    logic             mul;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             zr;
    logic             ng;
    logic             busy;

    modport master (
        output in_valid, x, y, zx, nx, zy, ny, f, no, mul, out_ready,
        input  in_ready, out_valid, out, zr, ng, busy
    );

    modport slave (
        input  in_valid, x, y, zx, nx, zy, ny, f, no, mul, out_ready,
        output in_ready, out_valid, out, zr, ng, busy
    );
endinterface

// File: rtl/alu_mc.sv
// Parametrised Hack ALU with a registered valid/ready result stage and an
// optional iterative shift-and-add multiply (low WIDTH bits of the product).
module alu_mc #(
    parameter int WIDTH  = 16,
    parameter int MUL_EN = 1
) (
    input  logic        clk,
    input  logic        reset,
    alu_mc_if.slave     bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    function automatic logic [WIDTH-1:0] f_prep(
        input logic [WIDTH-1:0] v,
        input logic             z,
        input logic             n
    );
        logic [WIDTH-1:0] t;
        t = z ? '0 : v;
        return n ? ~t : t;
    endfunction

    function automatic logic [WIDTH-1:0] f_hack(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             fn,
        input logic             neg
    );
        logic [WIDTH-1:0] r;
        r = fn ? (a + b) : (a & b);
        return neg ? ~r : r;
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_out;
    logic             r_zr;
    logic             r_ng;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_no;

    logic [WIDTH-1:0] w_xp;
    logic [WIDTH-1:0] w_yp;
    logic [WIDTH-1:0] w_hack;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_mul_res;
    logic             w_is_mul;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_mul_last;
    logic             w_busy;

    assign w_xp      = f_prep(bus.x, bus.zx, bus.nx);
    assign w_yp      = f_prep(bus.y, bus.zy, bus.ny);
    assign w_hack    = f_hack(w_xp, w_yp, bus.f, bus.no);
    // With MUL_EN=0 the mul input is ignored and the multiply path folds away.
    assign w_is_mul  = (MUL_EN != 0) && bus.mul;
    assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_mul_res = r_no ? ~w_acc_nxt : w_acc_nxt;
    assign w_mul_last = (r_state == S_MUL) && (r_cnt == CNT_W'(WIDTH - 1));
    assign w_accept  = bus.in_valid && w_in_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = !reset && (!r_out_valid || bus.out_ready);
                if (bus.in_valid && w_in_ready && w_is_mul) begin
                    w_state_nxt = S_MUL;
                end
            end
            S_MUL: begin
                w_busy = 1'b1;
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_out       <= '0;
            r_zr        <= 1'b0;
            r_ng        <= 1'b0;
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_no        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept && !w_is_mul) begin
                r_out       <= w_hack;
                r_zr        <= (w_hack == '0);
                r_ng        <= w_hack[WIDTH-1];
                r_out_valid <= 1'b1;
            end else if (w_accept) begin
                r_mcand     <= w_xp;
                r_mplier    <= w_yp;
                r_acc       <= '0;
                r_cnt       <= '0;
                r_no        <= bus.no;
                r_out_valid <= 1'b0;
            end else if (r_state == S_MUL) begin
                r_acc    <= w_acc_nxt;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 1'b1;
                if (w_mul_last) begin
                    r_out       <= w_mul_res;
                    r_zr        <= (w_mul_res == '0);
                    r_ng        <= w_mul_res[WIDTH-1];
                    r_out_valid <= 1'b1;
                end
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out       = r_out;
    assign bus.zr        = r_zr;
    assign bus.ng        = r_ng;
    assign bus.busy      = w_busy;
endmodule
